// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing a shared ALU and a unified
// memory port, with ready/request handshake, optional wait timeout and sticky trap.
module multicycle_control_unit #(
  parameter bit          ENABLE_BNE     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned TIMEOUT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_sel,
  output logic [1:0]  imm_sel,
  output logic [2:0]  alu_control,
  output logic        fault,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_TGT  = 4'd11,
    S_JALR_LINK = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 fault_q, fault_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       legal_alu_f3;
  logic       legal_br_f3;
  logic       in_wait;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign legal_alu_f3 = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);
  assign legal_br_f3  = (funct3 == 3'b000) || (ENABLE_BNE && (funct3 == 3'b001));

  assign state_o = state_q;
  assign fault   = fault_q;

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_op = sub ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  // State, wait counter and trap flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_sel     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_sel  = 2'b00;
    alu_control = ALU_ADD;
    in_wait     = 1'b0;

    case (opcode)
      OP_STORE:  imm_sel = 2'b01;
      OP_BRANCH: imm_sel = 2'b10;
      OP_JAL:    imm_sel = 2'b11;
      default:   imm_sel = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        in_wait    = 1'b1;
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_sel = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:  state_d = legal_alu_f3 ? S_EXECR : S_TRAP;
          OP_ITYPE:  state_d = legal_alu_f3 ? S_EXECI : S_TRAP;
          OP_BRANCH: state_d = legal_br_f3 ? S_BRANCH : S_TRAP;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR_TGT;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        in_wait = 1'b1;
        mem_req = 1'b1;
        adr_sel = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_sel = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        in_wait   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_sel   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_op(funct3, funct7_5);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_op(funct3, 1'b0);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = funct3[0] ? ~zero : zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR_TGT: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase

    // A ready in the final allowed wait cycle still takes the normal transition
    if (in_wait && !mem_ready && (TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST)) begin
      state_d = S_TRAP;
    end
  end

  // Wait counter and sticky fault
  always_comb begin
    wait_d  = wait_q;
    fault_d = fault_q | (state_d == S_TRAP);
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_wait && !mem_ready) begin
      wait_d = wait_q + TIMEOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected state and output vectors are
// queued as each cycle is driven and compared on the following falling edge.
module tb_multicycle_control_unit;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR_TGT = 4'd11,
                         S_JALR_LINK = 4'd12, S_TRAP = 4'd13;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] outv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic       mem_req, mem_write, adr_sel, ir_write, pc_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, result_sel, imm_sel;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  logic       nb_mem_req, nb_mem_write, nb_adr_sel, nb_ir_write, nb_pc_write, nb_reg_write, nb_fault;
  logic [1:0] nb_alu_src_a, nb_alu_src_b, nb_result_sel, nb_imm_sel;
  logic [2:0] nb_alu_control;
  logic [3:0] nb_state_o;

  logic [17:0] obs_vec;
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  string       cur_test = "init";

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_sel(adr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_sel(result_sel), .imm_sel(imm_sel), .alu_control(alu_control), .fault(fault),
    .state_o(state_o)
  );

  multicycle_control_unit #(.ENABLE_BNE(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(nb_mem_req), .mem_write(nb_mem_write), .adr_sel(nb_adr_sel), .ir_write(nb_ir_write),
    .pc_write(nb_pc_write), .reg_write(nb_reg_write), .alu_src_a(nb_alu_src_a),
    .alu_src_b(nb_alu_src_b), .result_sel(nb_result_sel), .imm_sel(nb_imm_sel),
    .alu_control(nb_alu_control), .fault(nb_fault), .state_o(nb_state_o)
  );

  assign obs_vec = {mem_req, mem_write, adr_sel, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, result_sel, imm_sel, alu_control, fault};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output table written from the state descriptions
  function automatic logic [17:0] out_exp(input logic [3:0] st, input logic [31:0] ins,
                                          input logic z, input logic mr);
    logic       req, mw, adr, irw, pcw, rw, flt;
    logic [1:0] a, b, rs, imm;
    logic [2:0] alu;
    req = 1'b0; mw = 1'b0; adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; flt = 1'b0;
    a = 2'b00; b = 2'b00; rs = 2'b00; alu = 3'b000;
    case (ins[6:0])
      7'h23:   imm = 2'b01;
      7'h63:   imm = 2'b10;
      7'h6F:   imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (st)
      S_FETCH:     begin req = 1'b1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      S_DECODE:    begin a = 2'b01; b = 2'b01; end
      S_MEMADR:    begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:   begin req = 1'b1; adr = 1'b1; end
      S_MEMWB:     begin rs = 2'b01; rw = 1'b1; end
      S_MEMWRITE:  begin req = 1'b1; mw = 1'b1; adr = 1'b1; end
      S_EXECR, S_EXECI: begin
        a = 2'b10;
        b = (st == S_EXECI) ? 2'b01 : 2'b00;
        case (ins[14:12])
          3'b000:  alu = (st == S_EXECR && ins[30]) ? 3'b001 : 3'b000;
          3'b010:  alu = 3'b101;
          3'b110:  alu = 3'b011;
          3'b111:  alu = 3'b010;
          default: alu = 3'b000;
        endcase
      end
      S_ALUWB:     rw = 1'b1;
      S_BRANCH:    begin a = 2'b10; alu = 3'b001; pcw = ins[12] ? ~z : z; end
      S_JAL:       begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      S_JALR_TGT:  begin a = 2'b10; b = 2'b01; end
      S_JALR_LINK: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      S_TRAP:      flt = 1'b1;
      default:     ;
    endcase
    return {req, mw, adr, irw, pcw, rw, a, b, rs, imm, alu, flt};
  endfunction

  // Scoreboard consumer: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val($sformatf("%s/state(exp %0d)", cur_test, e.st), 32'(state_o), 32'(e.st));
      check_val($sformatf("%s/outputs(st %0d)", cur_test, e.st), 32'(obs_vec), 32'(e.outv));
    end
  end

  task automatic step(input logic [3:0] st, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back('{st: st, outv: out_exp(st, instr, z, mr)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    cur_test  = name;
    rst       = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    @(posedge clk);
    #1;
    check_val({name, "/rst_state"}, 32'(state_o), 32'(S_FETCH));
    check_val({name, "/rst_outs"}, 32'(obs_vec), 32'(out_exp(S_FETCH, instr, 1'b0, 1'b1)));
    check_val({name, "/rst_nb_fault"}, 32'(nb_fault), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    #12;

    // add x3,x1,x2
    instr = 32'h002081B3;
    do_reset("add");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_EXECR, 1, 0);
    step(S_ALUWB, 1, 0); step(S_FETCH, 0, 0);

    // sub x2,x1,x2
    instr = 32'h40208133;
    do_reset("sub");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_EXECR, 1, 0);
    step(S_ALUWB, 1, 0); step(S_FETCH, 0, 0);

    // addi with immediate bit 30 set must stay add
    instr = 32'h40000013;
    do_reset("addi");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_EXECI, 1, 0);
    step(S_ALUWB, 1, 0); step(S_FETCH, 0, 0);

    // lw with three wait cycles in MEMREAD
    instr = 32'h00402283;
    do_reset("lw");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_MEMADR, 1, 0);
    for (int i = 0; i < 3; i++) step(S_MEMREAD, 0, 0);
    step(S_MEMREAD, 1, 0); step(S_MEMWB, 1, 0); step(S_FETCH, 0, 0);

    // sw x2,4(x1)
    instr = 32'h0020A223;
    do_reset("sw");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_MEMADR, 1, 0);
    step(S_MEMWRITE, 1, 0); step(S_FETCH, 0, 0);

    // beq taken and not taken
    instr = 32'h00000463;
    do_reset("beq_t");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_BRANCH, 1, 1); step(S_FETCH, 0, 0);
    do_reset("beq_nt");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_BRANCH, 1, 0); step(S_FETCH, 0, 0);

    // bne: legal on the default instance, traps when disabled
    instr = 32'h00001463;
    do_reset("bne");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0);
    check_val("bne/nb_state", 32'(nb_state_o), 32'(S_TRAP));
    check_val("bne/nb_fault", 32'(nb_fault), 32'd1);
    step(S_BRANCH, 1, 0); step(S_FETCH, 0, 0);
    check_val("bne/nb_held", 32'(nb_state_o), 32'(S_TRAP));

    // jal and jalr
    instr = 32'h0000006F;
    do_reset("jal");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_JAL, 1, 0);
    step(S_ALUWB, 1, 0); step(S_FETCH, 0, 0);
    instr = 32'h000100E7;
    do_reset("jalr");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_JALR_TGT, 1, 0);
    step(S_JALR_LINK, 1, 0); step(S_ALUWB, 1, 0); step(S_FETCH, 0, 0);

    // illegal R-type funct3 (sll) traps
    instr = 32'h00209133;
    do_reset("sll");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_TRAP, 1, 0);

    // all-zero instruction traps; async reset mid-cycle clears at once
    instr = 32'h00000000;
    do_reset("zero_instr");
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_TRAP, 1, 0); step(S_TRAP, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst/state", 32'(state_o), 32'(S_FETCH));
    check_val("async_rst/fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // FETCH timeout after eight unanswered cycles
    instr = 32'h002081B3;
    do_reset("timeout");
    for (int i = 0; i < 8; i++) step(S_FETCH, 0, 0);
    step(S_TRAP, 0, 0); step(S_TRAP, 1, 0);

    // ready on the eighth cycle wins
    do_reset("late_ready");
    for (int i = 0; i < 7; i++) step(S_FETCH, 0, 0);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_EXECR, 1, 0);

    // counter clears between wait states
    instr = 32'h00402283;
    do_reset("wait_clear");
    for (int i = 0; i < 5; i++) step(S_FETCH, 0, 0);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_MEMADR, 1, 0);
    for (int i = 0; i < 7; i++) step(S_MEMREAD, 0, 0);
    step(S_MEMREAD, 1, 0); step(S_MEMWB, 1, 0); step(S_FETCH, 0, 0);

    @(negedge clk);
    #1;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle successor to the single-cycle RV32I control unit. It sequences each instruction through a Moore FSM over a shared ALU and a unified instruction/data memory port, and adds a ready/request memory handshake with an optional timeout. It also adds parametrised bne support and detection of illegal instructions, which go to a sticky trap state. It sits between the instruction register and the multicycle datapath (PC, IR, old-PC, ALU-out and data registers).

Parameters:
ENABLE_BNE, 1, 1 = funct3 001 branch is legal (bne); 0 = it traps
TIMEOUT_CYCLES, 8, consecutive mem_ready-low cycles in a wait state before trapping; 0 disables the timeout
TIMEOUT_W, 4, width of the wait counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr  in  32  instruction register contents; valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepts or completes the current request this cycle
mem_req  out  1  memory request
mem_write  out  1  store strobe; qualified by mem_req
adr_sel  out  1  0 = PC, 1 = ALU-out register
ir_write  out  1  load IR and old-PC
pc_write  out  1  load PC
reg_write  out  1  register file write
alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
result_sel  out  2  00 = ALU-out register, 01 = data register, 10 = ALU result
imm_sel  out  2  00 = I, 01 = S, 10 = B, 11 = J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
fault  out  1  sticky trap flag
state_o  out  4  current state (debug)

Behaviour:
- Reset (async): state goes to FETCH, wait counter to 0, fault to 0. All outputs take their FETCH values while rst is held. Reset mid-access aborts the access; no write strobes are issued afterwards.
- Outputs are Moore, decoded from state, except the following:
  - imm_sel: combinational from opcode in every state (lw/I/jalr 00, sw 01, branch 10, jal 11, others 00).
  - alu_control in EXECR/EXECI: combinational from funct3 and funct7[5].
  - pc_write/ir_write in FETCH, and pc_write in BRANCH: gated by inputs as described below.
- Unlisted outputs are 0; the ALU default is add.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR_TGT 11, JALR_LINK 12, TRAP 13.
- FETCH: mem_req=1, adr_sel=0, a=PC, b=4, result_sel=10. If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE: a=old PC, b=imm, add (branch/jal target into ALU-out). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXECR
  - I-type → EXECI
  - beq/bne → BRANCH
  - jal → JAL
  - jalr → JALR_TGT
  - any other opcode → TRAP
  - Also → TRAP: R/I funct3 not in {000, 010, 110, 111}; branch funct3 not 000 (or 001 when ENABLE_BNE=1).
- MEMADR: a=rs1, b=imm, add. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: mem_req=1, adr_sel=1. Go to MEMWB on mem_ready.
- MEMWB: result_sel=01, reg_write=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_sel=1. Go to FETCH on mem_ready.
- EXECR: a=rs1, b=rs2. funct3 000 gives sub if funct7[5]=1, else add. 010 slt, 110 or, 111 and. Go to ALUWB.
- EXECI: a=rs1, b=imm, same funct3 map, funct3 000 is always add. Go to ALUWB.
- ALUWB: result_sel=00, reg_write=1, go to FETCH.
- BRANCH: a=rs1, b=rs2, sub, result_sel=00. pc_write = zero for beq, ~zero for bne. Go to FETCH.
- JAL: a=old PC, b=4, add, result_sel=00, pc_write=1 (target), go to ALUWB (writes PC+4).
- JALR_TGT: a=rs1, b=imm, add, go to JALR_LINK.
- JALR_LINK: a=old PC, b=4, result_sel=00, pc_write=1, go to ALUWB.
- Wait states are FETCH, MEMREAD and MEMWRITE.
  - The counter increments on each mem_ready-low cycle and clears on every state change.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 while mem_ready=0, the next state is TRAP.
  - mem_ready=1 on that same cycle wins: the normal transition is taken.
- TRAP: fault=1, all strobes 0, remains until rst.
- Latency with zero wait: R/I 4 cycles, lw 5, sw 4, branch 3, jal 4, jalr 5.

Test Plan:
- Reset, mem_ready=1, instr=0x002081B3 (add x3,x1,x2) → state_o 0,1,6,8,0. EXECR alu_control=000. Exactly one cycle reg_write=1, in ALUWB.
- instr=0x00402283 (lw), mem_ready low 3 cycles in MEMREAD → mem_req=1 and adr_sel=1 held for 4 cycles. MEMWB has result_sel=01 and reg_write=1. Total 8 cycles.
- instr=0x00000463 (beq) with zero=1 → pc_write=1 in BRANCH. With zero=0 → pc_write=0. instr=0x00001463 (bne), ENABLE_BNE=0 → TRAP after DECODE, fault=1.
- instr=0x000100E7 (jalr) → states 0,1,11,12,8. pc_write in FETCH and JALR_LINK only. reg_write in ALUWB.
- instr=0x00000000 → TRAP, fault=1 held; async rst mid-cycle → state_o=0 and fault=0 immediately.
- TIMEOUT_CYCLES=8, mem_ready held 0 in FETCH → TRAP after 8 cycles. mem_ready=1 in the 8th cycle instead → DECODE, no fault.
